// File: rtl/mem_pkg.sv
// Shared types and encodings for the load/store unit and its memory port.
package mem_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1024;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] BHW_WORD = 2'b00;
  localparam logic [1:0] BHW_HALF = 2'b01;
  localparam logic [1:0] BHW_BYTE = 2'b10;

  // Registered request presented to memory.
  typedef struct packed {
    logic            rw;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [1:0]      bhw;
    logic            load_unsigned;
  } mem_req_t;

endpackage

// File: rtl/lsu_decode.sv
// Combinational funct3 decode and alignment check for a MEM-stage request.
module lsu_decode
  import mem_pkg::*;
(
  input  logic       i_is_store,
  input  logic [2:0] i_funct3,
  input  logic [1:0] i_addr_lo,
  output logic       o_illegal,
  output logic       o_misaligned,
  output logic [1:0] o_bhw,
  output logic       o_load_unsigned
);

  logic w_legal;

  always_comb begin
    w_legal         = 1'b0;
    o_bhw           = BHW_WORD;
    o_load_unsigned = 1'b0;
    case (i_funct3)
      F3_B:  begin w_legal = 1'b1;        o_bhw = BHW_BYTE; end
      F3_H:  begin w_legal = 1'b1;        o_bhw = BHW_HALF; end
      F3_W:  begin w_legal = 1'b1;        o_bhw = BHW_WORD; end
      F3_BU: begin w_legal = !i_is_store; o_bhw = BHW_BYTE; o_load_unsigned = !i_is_store; end
      F3_HU: begin w_legal = !i_is_store; o_bhw = BHW_HALF; o_load_unsigned = !i_is_store; end
      default: w_legal = 1'b0;
    endcase
    o_illegal = !w_legal;
    // Alignment only has meaning once the access size is known.
    o_misaligned = w_legal &&
                   (((o_bhw == BHW_WORD) && (i_addr_lo != 2'b00)) ||
                    ((o_bhw == BHW_HALF) && i_addr_lo[0]));
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: decodes a request, runs one memory handshake with
// timeout, and returns a one-cycle response with exception flags.
module load_store_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic            req_is_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [4:0]      req_rd,
  output logic            stall,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic [4:0]      resp_rd,
  output logic            exc_misaligned,
  output logic            exc_illegal,
  output logic            exc_access_fault,
  output logic [XLEN-1:0] exc_addr,
  output logic            mem_valid,
  output logic            mem_rw,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_data_in,
  output logic [1:0]      mem_byte_half_word,
  output logic            mem_is_load_unsigned,
  input  logic            mem_ready,
  input  logic            mem_out_of_range,
  input  logic [XLEN-1:0] mem_data_out
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e      r_state;
  logic [CNT_W-1:0] r_cnt;
  mem_req_t        r_mem;
  logic [4:0]      r_rd;
  logic            r_mem_valid;
  logic            r_resp_valid;
  logic [XLEN-1:0] r_resp_rdata;
  logic [4:0]      r_resp_rd;
  logic            r_exc_mis;
  logic            r_exc_ill;
  logic            r_exc_af;
  logic [XLEN-1:0] r_exc_addr;

  logic       w_illegal;
  logic       w_misaligned;
  logic [1:0] w_bhw;
  logic       w_load_unsigned;
  logic       w_timeout;
  logic       w_complete;
  logic       w_fault;

  lsu_decode u_decode (
    .i_is_store      (req_is_store),
    .i_funct3        (req_funct3),
    .i_addr_lo       (req_addr[1:0]),
    .o_illegal       (w_illegal),
    .o_misaligned    (w_misaligned),
    .o_bhw           (w_bhw),
    .o_load_unsigned (w_load_unsigned)
  );

  // A ready arriving on the last counted cycle still completes successfully.
  assign w_timeout  = (r_cnt == CNT_LAST) && !mem_ready;
  assign w_complete = mem_ready || mem_out_of_range || (r_cnt == CNT_LAST);
  assign w_fault    = mem_out_of_range || w_timeout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_mem        <= '0;
      r_rd         <= '0;
      r_mem_valid  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_rd    <= '0;
      r_exc_mis    <= 1'b0;
      r_exc_ill    <= 1'b0;
      r_exc_af     <= 1'b0;
      r_exc_addr   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_rd                <= req_rd;
            r_mem.rw            <= req_is_store;
            r_mem.addr          <= req_addr;
            r_mem.data          <= req_wdata;
            r_mem.bhw           <= w_bhw;
            r_mem.load_unsigned <= w_load_unsigned;
            if (w_illegal || w_misaligned) begin
              r_state      <= ST_DONE;
              r_resp_valid <= 1'b1;
              r_resp_rd    <= req_rd;
              r_exc_ill    <= w_illegal;
              r_exc_mis    <= w_misaligned;
              r_exc_addr   <= req_addr;
            end else begin
              r_state     <= ST_ACCESS;
              r_mem_valid <= 1'b1;
              r_cnt       <= '0;
            end
          end
        end
        ST_ACCESS: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_complete) begin
            r_state      <= ST_DONE;
            r_mem_valid  <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_rd    <= r_rd;
            r_exc_af     <= w_fault;
            r_exc_addr   <= w_fault ? r_mem.addr : '0;
            r_resp_rdata <= (!r_mem.rw && !w_fault && (r_rd != 5'd0)) ? mem_data_out : '0;
          end
        end
        ST_DONE: begin
          r_state      <= ST_IDLE;
          r_resp_valid <= 1'b0;
          r_resp_rdata <= '0;
          r_resp_rd    <= '0;
          r_exc_mis    <= 1'b0;
          r_exc_ill    <= 1'b0;
          r_exc_af     <= 1'b0;
          r_exc_addr   <= '0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Hold is combinational so the pipeline freezes in the acceptance cycle.
  assign stall = rst && (((r_state == ST_IDLE) && req_valid) || (r_state == ST_ACCESS));

  assign resp_valid           = r_resp_valid;
  assign resp_rdata           = r_resp_rdata;
  assign resp_rd              = r_resp_rd;
  assign exc_misaligned       = r_exc_mis;
  assign exc_illegal          = r_exc_ill;
  assign exc_access_fault     = r_exc_af;
  assign exc_addr             = r_exc_addr;
  assign mem_valid            = r_mem_valid;
  assign mem_rw               = r_mem.rw;
  assign mem_addr             = r_mem.addr;
  assign mem_data_in          = r_mem.data;
  assign mem_byte_half_word   = r_mem.bhw;
  assign mem_is_load_unsigned = r_mem.load_unsigned;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a transaction-level model with
// a planned memory responder and a per-cycle output compare.
module tb_load_store_unit;
  import mem_pkg::*;

  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        stall, resp_valid;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        exc_misaligned, exc_illegal, exc_access_fault;
  logic [31:0] exc_addr;
  logic        mem_valid, mem_rw;
  logic [31:0] mem_addr, mem_data_in;
  logic [1:0]  mem_byte_half_word;
  logic        mem_is_load_unsigned;
  logic        mem_ready, mem_out_of_range;
  logic [31:0] mem_data_out;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_is_store(req_is_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd),
    .exc_misaligned(exc_misaligned), .exc_illegal(exc_illegal),
    .exc_access_fault(exc_access_fault), .exc_addr(exc_addr),
    .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_byte_half_word(mem_byte_half_word), .mem_is_load_unsigned(mem_is_load_unsigned),
    .mem_ready(mem_ready), .mem_out_of_range(mem_out_of_range), .mem_data_out(mem_data_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle expectations, written by the stimulus process.
  bit          chk_en = 1'b0, in_accept = 1'b0;
  bit          e_stall, e_mv, e_rv, e_rw, e_uns, e_mis, e_ill, e_af;
  logic [31:0] e_addr, e_wdata, e_rdata, e_eaddr;
  logic [1:0]  e_bhw;
  logic [4:0]  e_rd;

  // Observations of the most recent transaction, for literal pins.
  int          ncyc = 0, acc_cyc = 0, c_lat = -1, c_mv = 0;
  bit          c_mv_seen;
  logic        c_rw, c_uns, c_mis, c_ill, c_af;
  logic [1:0]  c_bhw;
  logic [31:0] c_rdata, c_eaddr;

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", stall, e_stall);
      check("mem_valid", mem_valid, e_mv);
      check("resp_valid", resp_valid, e_rv);
      if (e_mv) begin
        check("mem_rw", mem_rw, e_rw);
        check("mem_addr", mem_addr, e_addr);
        check("mem_data_in", mem_data_in, e_wdata);
        check("mem_bhw", mem_byte_half_word, e_bhw);
        check("mem_unsigned", mem_is_load_unsigned, e_uns);
      end
      if (e_rv) begin
        check("resp_rdata", resp_rdata, e_rdata);
        check("resp_rd", resp_rd, e_rd);
        check("exc_misaligned", exc_misaligned, e_mis);
        check("exc_illegal", exc_illegal, e_ill);
        check("exc_access_fault", exc_access_fault, e_af);
        check("exc_addr", exc_addr, e_eaddr);
      end else begin
        check("exc_idle", {exc_misaligned, exc_illegal, exc_access_fault}, 32'd0);
      end
      if (in_accept) begin
        acc_cyc = ncyc; c_mv = 0; c_mv_seen = 0; c_lat = -1;
        c_rdata = 32'hDEADBEEF; {c_mis, c_ill, c_af} = 3'b111; c_eaddr = 32'hDEADBEEF;
      end
      if (mem_valid) begin
        c_mv++;
        if (!c_mv_seen) begin
          c_mv_seen = 1; c_rw = mem_rw; c_bhw = mem_byte_half_word; c_uns = mem_is_load_unsigned;
        end
      end
      if (resp_valid) begin
        c_lat = ncyc - acc_cyc; c_rdata = resp_rdata; c_eaddr = exc_addr;
        c_mis = exc_misaligned; c_ill = exc_illegal; c_af = exc_access_fault;
      end
    end
    ncyc++;
  end

  // Bench memory: word store with lane select and load extension.
  logic [31:0] mem_words [int unsigned];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_words.exists(int'(a[31:2]))) return mem_words[int'(a[31:2])];
    return {a[31:2], 2'b00} ^ 32'h5A3C_96E1;
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] w;
    w = mem_word(a) >> (8 * int'(a[1:0]));
    case (f3)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'd0, w[7:0]};
      3'b101:  return {16'd0, w[15:0]};
      default: return w;
    endcase
  endfunction

  task automatic mem_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    int off;
    w = mem_word(a);
    off = 8 * int'(a[1:0]);
    case (f3[1:0])
      2'b00:   w[off +: 8]  = d[7:0];
      2'b01:   w[off +: 16] = d[15:0];
      default: w = d;
    endcase
    mem_words[int'(a[31:2])] = w;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic noise_req(input bit v);
    req_valid = v; req_is_store = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
  endtask

  task automatic noise_mem();
    mem_ready = 1'($urandom); mem_out_of_range = 1'($urandom); mem_data_out = $urandom;
  endtask

  task automatic idle_cycle();
    tick();
    in_accept = 0; noise_req(1'b0); noise_mem();
    e_stall = 0; e_mv = 0; e_rv = 0;
  endtask

  // One request from acceptance to response; lat = wait cycles before ready.
  task automatic run_txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd,
                         input int lat, input bit oor, input int gap);
    bit legal, mis, tmo, fault;
    int n;
    logic [31:0] ret;
    legal = st ? (f3 inside {3'b000, 3'b001, 3'b010})
               : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    mis   = legal && (((f3[1:0] == 2'b10) && (a[1:0] != 2'b00)) ||
                      ((f3[1:0] == 2'b01) && a[0]));
    tmo   = (lat + 1) > int'(TMO);
    n     = tmo ? int'(TMO) : lat + 1;
    fault = legal && !mis && (tmo || oor);
    ret   = st ? $urandom : load_val(a, f3);

    tick();
    in_accept = 1; noise_mem();
    req_valid = 1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
    e_stall = 1; e_mv = 0; e_rv = 0;
    e_rw = st; e_addr = a; e_wdata = wd; e_uns = !st && f3[2];
    e_bhw = (f3[1:0] == 2'b00) ? BHW_BYTE : (f3[1:0] == 2'b01) ? BHW_HALF : BHW_WORD;

    if (legal && !mis) begin
      for (int k = 1; k <= n; k++) begin
        tick();
        in_accept = 0; noise_req(1'($urandom));
        mem_ready        = (k == lat + 1);
        mem_out_of_range = (k == lat + 1) && oor;
        mem_data_out     = (k == lat + 1) ? ret : $urandom;
        e_stall = 1; e_mv = 1;
      end
      if (st && !fault) mem_store(a, f3, wd);
    end

    tick();
    in_accept = 0; noise_req(1'($urandom)); noise_mem();
    e_stall = 0; e_mv = 0; e_rv = 1;
    e_rd = rd; e_mis = mis; e_ill = !legal; e_af = fault;
    e_eaddr = (!legal || mis || fault) ? a : 32'd0;
    e_rdata = (legal && !mis && !st && !fault && rd != 5'd0) ? ret : 32'd0;

    for (int g = 0; g < gap; g++) idle_cycle();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, stall, 32'd0);
    check({tag, "_mem_valid"}, mem_valid, 32'd0);
    check({tag, "_resp_valid"}, resp_valid, 32'd0);
    check({tag, "_resp"}, resp_rdata | 32'(resp_rd) | exc_addr, 32'd0);
    check({tag, "_exc"}, {exc_misaligned, exc_illegal, exc_access_fault}, 32'd0);
    check({tag, "_mem_fields"}, mem_addr | mem_data_in |
          32'({mem_rw, mem_byte_half_word, mem_is_load_unsigned}), 32'd0);
  endtask

  initial begin
    bit st;
    logic [2:0] f3;
    logic [4:0] rd;

    noise_req(1'b1); mem_ready = 1; mem_out_of_range = 1; mem_data_out = $urandom;
    repeat (3) begin
      @(negedge clk);
      check_all_zero("reset");
    end
    @(posedge clk); #1;
    rst = 1; noise_req(1'b0);
    e_stall = 0; e_mv = 0; e_rv = 0; chk_en = 1;
    idle_cycle();

    // Store then load back the same word.
    run_txn(1'b1, 3'b010, 32'h0000_9418, 32'h6A70_A30C, 5'd3, 1, 1'b0, 1);
    check("sw_mem_rw", c_rw, 32'd1);
    check("sw_fault", c_af, 32'd0);
    run_txn(1'b0, 3'b010, 32'h0000_9418, $urandom, 5'd7, 0, 1'b0, 1);
    check("lw_mem_rw", c_rw, 32'd0);
    check("lw_rdata", c_rdata, 32'h6A70_A30C);
    check("lw_latency", 32'(c_lat), 32'd2);
    check("lw_exc", {c_mis, c_ill, c_af}, 32'd0);

    run_txn(1'b0, 3'b100, 32'h0000_9419, $urandom, 5'd9, 2, 1'b0, 1);
    check("lbu_rdata", c_rdata, 32'h0000_00A3);
    check("lbu_bhw", c_bhw, 32'd2);
    check("lbu_unsigned", c_uns, 32'd1);

    run_txn(1'b0, 3'b010, 32'h0000_941B, $urandom, 5'd4, 0, 1'b0, 1);
    check("mis_flag", c_mis, 32'd1);
    check("mis_addr", c_eaddr, 32'h0000_941B);
    check("mis_mem_cycles", 32'(c_mv), 32'd0);
    check("mis_latency", 32'(c_lat), 32'd1);

    run_txn(1'b0, 3'b010, 32'h0000_F45C, $urandom, 5'd5, 2, 1'b1, 1);
    check("oor_fault", c_af, 32'd1);
    check("oor_rdata", c_rdata, 32'd0);

    run_txn(1'b0, 3'b010, 32'h0000_9420, $urandom, 5'd6, 50, 1'b0, 1);
    check("tmo_fault", c_af, 32'd1);
    check("tmo_mem_cycles", 32'(c_mv), 32'd8);
    check("tmo_latency", 32'(c_lat), 32'd9);

    run_txn(1'b1, 3'b100, 32'h0000_9424, $urandom, 5'd2, 0, 1'b0, 1);
    check("ill_flag", c_ill, 32'd1);

    // Reset in the middle of a memory wait.
    tick();
    in_accept = 1; noise_mem();
    req_valid = 1; req_is_store = 0; req_funct3 = 3'b010; req_addr = 32'h0000_9430;
    req_wdata = 0; req_rd = 5'd8;
    e_stall = 1; e_mv = 0; e_rv = 0;
    e_rw = 0; e_addr = 32'h0000_9430; e_wdata = 0; e_uns = 0; e_bhw = BHW_WORD;
    for (int k = 0; k < 3; k++) begin
      tick();
      in_accept = 0; req_valid = 0; mem_ready = 0; mem_out_of_range = 0;
      e_stall = 1; e_mv = 1;
    end
    tick();
    chk_en = 0; mem_ready = 0; mem_out_of_range = 0;
    #1 rst = 0; req_valid = 1;
    #1;
    check("rst_mem_valid", mem_valid, 32'd0);
    check("rst_stall", stall, 32'd0);
    check("rst_resp_valid", resp_valid, 32'd0);
    @(negedge clk);
    check_all_zero("midrst");
    @(posedge clk); #1;
    rst = 1; noise_req(1'b0);
    e_stall = 0; e_mv = 0; e_rv = 0; chk_en = 1;
    run_txn(1'b0, 3'b010, 32'h0000_9418, $urandom, 5'd10, 1, 1'b0, 1);
    check("post_rst_rdata", c_rdata, 32'h6A70_A30C);
    check("post_rst_fault", c_af, 32'd0);

    // Randomized traffic.
    for (int t = 0; t < 250; t++) begin
      st = 1'($urandom);
      if ($urandom_range(0, 7) == 0) f3 = 3'($urandom);
      else if (st) f3 = 3'($urandom_range(0, 2));
      else begin
        f3 = 3'($urandom_range(0, 4));
        if (f3 > 3'd2) f3 = f3 + 3'd1;
      end
      rd = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
      run_txn(st, f3, 32'h0000_9400 + 32'($urandom_range(0, 63)), $urandom, rd,
              $urandom_range(0, 9), ($urandom_range(0, 7) == 0), $urandom_range(0, 2));
    end
    repeat (3) idle_cycle();
    @(negedge clk);
    chk_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning memory cycles waited for ready/out_of_range before a fault.
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req_valid in 1, req_is_store in 1, req_funct3 in 3, req_addr in 32, req_wdata in 32, req_rd in 5: pipeline MEM-stage request.
REQ-005 SHALL have ports stall out 1, resp_valid out 1, resp_rdata out 32, resp_rd out 5: pipeline hold and response.
REQ-006 SHALL have ports exc_misaligned out 1, exc_illegal out 1, exc_access_fault out 1, exc_addr out 32: exception report, valid with resp_valid.
REQ-007 SHALL have ports mem_valid out 1, mem_rw out 1 (1=store), mem_addr out 32, mem_data_in out 32, mem_byte_half_word out 2 (00 word, 01 half, 10 byte), mem_is_load_unsigned out 1: memory request.
REQ-008 SHALL have ports mem_ready in 1, mem_out_of_range in 1, mem_data_out in 32: memory completion.

Function
REQ-009 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-010 SHALL accept a request in IDLE when req_valid=1, registering all req_* fields that cycle.
REQ-011 SHALL decode loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores: 000 SB, 001 SH, 010 SW; any other code sets exc_illegal.
REQ-012 SHALL flag exc_misaligned for word with addr[1:0]!=0 or half with addr[0]!=0.
REQ-013 SHALL, on an illegal or misaligned request, skip memory (mem_valid stays 0) and go IDLE->DONE.
REQ-014 SHALL, on a legal request, go IDLE->ACCESS and drive mem_valid=1 from the next cycle with registered mem_* fields held stable.
REQ-015 SHALL pass req_wdata unmodified to mem_data_in; lane selection and load extension are done by memory.
REQ-016 SHALL leave ACCESS for DONE on the first cycle mem_ready=1 or mem_out_of_range=1, or when the wait counter reaches TIMEOUT_CYCLES-1; mem_valid drops to 0 the following cycle.
REQ-017 SHALL treat mem_out_of_range=1 or timeout as exc_access_fault; when mem_ready and mem_out_of_range are high together, the fault wins.
REQ-018 SHALL register mem_data_out into resp_rdata on load completion; resp_rdata=0 for stores, faults, or req_rd=0.
REQ-019 SHALL assert resp_valid, resp_rd, and the exception flags for exactly one cycle in DONE, then return to IDLE.
REQ-020 SHALL ensure mem_valid is low for at least one cycle between consecutive memory transactions.
REQ-021 SHALL drive stall combinationally = (IDLE & req_valid) | ACCESS; stall=0 in DONE.
REQ-022 SHALL ignore req_valid while in DONE.
REQ-023 SHALL set exc_addr to the registered request address when any exception flag is set, otherwise 0.
REQ-024 SHALL use total latency for a legal access of 2 + N cycles from acceptance to resp_valid, where N is the number of mem_valid cycles before completion.

Reset
REQ-025 SHALL, when rst=0, immediately force state IDLE and all outputs 0, including mid-ACCESS, with mem_valid dropping asynchronously.
REQ-026 SHALL clear the wait counter on reset and on every ACCESS entry.

Structure
REQ-027 SHALL place the state enum, funct3 constants, byte_half_word encodings and TIMEOUT_CYCLES default in shared package mem_pkg.
REQ-028 SHALL isolate funct3 decode and alignment check in combinational sub-module lsu_decode.

Verification
REQ-029 SHALL cover: SW addr 0x9418 data 0x6A70A30C, then LW 0x9418 -> mem_rw=1 then 0, resp_rdata=0x6A70A30C, no exceptions.
REQ-030 SHALL cover: LBU funct3=100 addr 0x9419, memory returns 0x000000A3 -> mem_byte_half_word=10, mem_is_load_unsigned=1, resp_rdata=0x000000A3.
REQ-031 SHALL cover: LW addr 0x941B -> exc_misaligned=1, exc_addr=0x941B, mem_valid never asserted, resp_valid 1 cycle after acceptance.
REQ-032 SHALL cover: LW addr 0xF45C with memory asserting mem_out_of_range -> exc_access_fault=1, resp_rdata=0.
REQ-033 SHALL cover: TIMEOUT_CYCLES=8 and mem_ready held 0 -> exc_access_fault after exactly 8 mem_valid cycles.
REQ-034 SHALL cover: rst=0 asserted mid-ACCESS -> mem_valid=0 immediately, stall=0, and a fresh request after release completes normally.
